cdb_broadcaster: RTL

//  Transmit side of the Common Data Bus (CDB). Collects completed results from the

---
 rtl/cdb_broadcaster.sv | 128 ++++++++++++
 1 files changed

// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster: buffers one completed result per FU and round-robin packs up to
// CDB_WIDTH of them per cycle onto the registered Common Data Bus.
module cdb_broadcaster #(
  parameter int FU_NUM    = 5,
  parameter int CDB_WIDTH = 3,
  parameter int ROB_SIZE  = 32,
  parameter int XLEN      = 32,
  localparam int TW       = $clog2(ROB_SIZE)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [FU_NUM-1:0] fu_valid_i,
  input  logic [TW-1:0]     fu_tag_i   [FU_NUM],
  input  logic [XLEN-1:0]   fu_value_i [FU_NUM],
  output logic [FU_NUM-1:0] fu_ready_o,
  output logic              complete_en_o,
  output logic [1:0]        rob_complete_num_o,
  output logic [TW-1:0]     cdb_tag_o   [CDB_WIDTH],
  output logic [XLEN-1:0]   cdb_value_o [CDB_WIDTH]
);

  localparam int PW = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
  localparam logic [PW:0] FU_NUM_W = (PW+1)'(FU_NUM);
  localparam logic [2:0]  CW       = 3'(CDB_WIDTH);

  logic [FU_NUM-1:0] hold_valid_q;
  logic [TW-1:0]     hold_tag_q   [FU_NUM];
  logic [XLEN-1:0]   hold_value_q [FU_NUM];
  logic [PW-1:0]     rr_q, rr_d;

  logic [FU_NUM-1:0] grant_d;
  logic [FU_NUM-1:0] accept;
  logic [2:0]        cnt_d;
  logic [TW-1:0]     slot_tag_d   [CDB_WIDTH];
  logic [XLEN-1:0]   slot_value_d [CDB_WIDTH];

  logic              complete_en_q;
  logic [1:0]        num_q;
  logic [TW-1:0]     cdb_tag_q   [CDB_WIDTH];
  logic [XLEN-1:0]   cdb_value_q [CDB_WIDTH];

  // Grant uses registered holds only, so fu_ready never depends on fu_valid.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic [PW-1:0] last_idx;
    grant_d  = '0;
    cnt_d    = '0;
    sum      = '0;
    idx      = '0;
    last_idx = '0;
    for (int s = 0; s < CDB_WIDTH; s++) begin
      slot_tag_d[s]   = '0;
      slot_value_d[s] = '0;
    end
    for (int k = 0; k < FU_NUM; k++) begin
      sum = {1'b0, rr_q} + (PW+1)'(k);
      if (sum >= FU_NUM_W) sum = sum - FU_NUM_W;
      idx = sum[PW-1:0];
      if (hold_valid_q[idx] && (cnt_d < CW)) begin
        grant_d[idx] = 1'b1;
        for (int s = 0; s < CDB_WIDTH; s++) begin
          if (cnt_d == 3'(s)) begin
            slot_tag_d[s]   = hold_tag_q[idx];
            slot_value_d[s] = hold_value_q[idx];
          end
        end
        cnt_d    = cnt_d + 3'd1;
        last_idx = idx;
      end
    end
    rr_d = (last_idx == PW'(FU_NUM-1)) ? '0 : last_idx + PW'(1);
  end

  assign fu_ready_o = ~{FU_NUM{flush_i}} & (~hold_valid_q | grant_d);
  assign accept     = fu_valid_i & fu_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid_q  <= '0;
      rr_q          <= '0;
      complete_en_q <= 1'b0;
      num_q         <= '0;
      for (int i = 0; i < FU_NUM; i++) begin
        hold_tag_q[i]   <= '0;
        hold_value_q[i] <= '0;
      end
      for (int s = 0; s < CDB_WIDTH; s++) begin
        cdb_tag_q[s]   <= '0;
        cdb_value_q[s] <= '0;
      end
    end else if (flush_i) begin
      hold_valid_q  <= '0;
      rr_q          <= '0;
      complete_en_q <= 1'b0;
      num_q         <= '0;
      for (int s = 0; s < CDB_WIDTH; s++) begin
        cdb_tag_q[s]   <= '0;
        cdb_value_q[s] <= '0;
      end
    end else begin
      // A new result loading into an entry wins over that entry's grant-clear.
      for (int i = 0; i < FU_NUM; i++) begin
        if (accept[i]) begin
          hold_valid_q[i] <= 1'b1;
          hold_tag_q[i]   <= fu_tag_i[i];
          hold_value_q[i] <= fu_value_i[i];
        end else if (grant_d[i]) begin
          hold_valid_q[i] <= 1'b0;
        end
      end
      for (int s = 0; s < CDB_WIDTH; s++) begin
        cdb_tag_q[s]   <= slot_tag_d[s];
        cdb_value_q[s] <= slot_value_d[s];
      end
      num_q         <= cnt_d[1:0];
      complete_en_q <= (cnt_d != 3'd0);
      if (cnt_d != 3'd0) rr_q <= rr_d;
    end
  end

  assign complete_en_o      = complete_en_q;
  assign rob_complete_num_o = num_q;
  assign cdb_tag_o          = cdb_tag_q;
  assign cdb_value_o        = cdb_value_q;

endmodule
